// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity-type codes and the default baud setup.
// Used by both transmitter and receiver so that frame layout and parity stay bit-compatible.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int BASE_FREQ = 50_000_000;
    localparam int BAUDRATE  = 115_200;

    // Codes 2 and 3 both mean odd; "none" still fills the slot with a 1.
    function automatic logic parity_bit(input logic [1:0] ptype, input logic data_xor);
        if (ptype == PAR_NONE) begin
            return 1'b1;
        end else if ((ptype & PAR_ODD) != 2'd0) begin
            return ~data_xor;
        end else begin
            return data_xor;
        end
    endfunction

endpackage

// File: rtl/transmitter_if.sv
// Host-side word handshake into the UART transmitter.
// master = data source, slave = transmitter.
interface transmitter_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic [1:0]           parity_type;
    logic                 tx_ready;
    logic                 tx_done;

    modport master (
        output tx_valid, tx_data, parity_type,
        input  tx_ready, tx_done
    );

    modport slave (
        input  tx_valid, tx_data, parity_type,
        output tx_ready, tx_done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..COUNTS_PER_BIT-1 and strobes bit_end on the last count.
// Wraps to 0 after bit_end; clr holds it at 0 synchronously.
module uart_bit_timer #(
    parameter int COUNTS_PER_BIT  = 434,
    parameter int CLOCK_CTR_WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);
    logic [CLOCK_CTR_WIDTH-1:0] ctr_q, ctr_d;

    assign bit_end = (ctr_q == CLOCK_CTR_WIDTH'(COUNTS_PER_BIT - 1));

    always_comb begin
        ctr_d = ctr_q + CLOCK_CTR_WIDTH'(1);
        if (clr || bit_end) begin
            ctr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_q <= '0;
        end else begin
            ctr_q <= ctr_d;
        end
    end
endmodule

// File: rtl/transmitter.sv
// UART transmitter: start, DATA_BITS data (LSB first), parity slot, one stop bit.
// Line falls one cycle after accept; ready is low for the whole frame and rises with tx_done.
module transmitter
    import uart_pkg::*;
#(
    parameter int COUNTS_PER_BIT  = BASE_FREQ / BAUDRATE,
    parameter int DATA_BITS       = 8,
    parameter int CLOCK_CTR_WIDTH = 32,
    parameter int D_IDX_WIDTH     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1
) (
    input  logic         clk,
    input  logic         rst,
    transmitter_if.slave tx_if,
    output logic         serial_data_out
);
    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [D_IDX_WIDTH-1:0] d_idx_q, d_idx_d;
    logic                   par_q, par_d;
    logic                   line_q, line_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    uart_bit_timer #(
        .COUNTS_PER_BIT (COUNTS_PER_BIT),
        .CLOCK_CTR_WIDTH(CLOCK_CTR_WIDTH)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == IDLE),
        .bit_end(bit_end)
    );

    assign serial_data_out = line_q;
    assign tx_if.tx_ready  = ready_q;
    assign tx_if.tx_done   = done_q;

    // Outputs are computed from the next state so the line and ready come straight off flops.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        d_idx_d = d_idx_q;
        par_d   = par_q;
        line_d  = line_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                line_d  = 1'b1;
                ready_d = 1'b1;
                if (tx_if.tx_valid && ready_q) begin
                    state_d = START;
                    sh_d    = tx_if.tx_data;
                    par_d   = parity_bit(tx_if.parity_type, ^tx_if.tx_data);
                    line_d  = 1'b0;
                    ready_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    line_d  = sh_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (d_idx_q == D_IDX_WIDTH'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                        d_idx_d = '0;
                        line_d  = par_q;
                    end else begin
                        d_idx_d = d_idx_q + D_IDX_WIDTH'(1);
                        sh_d    = sh_q >> 1;
                        line_d  = sh_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    line_d  = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    line_d  = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sh_d    = '0;
                d_idx_d = '0;
                line_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            d_idx_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            d_idx_q <= d_idx_d;
            par_q   <= par_d;
            line_q  <= line_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end
endmodule
